// File: rtl/universal_shift_register.sv
// Universal shift register: hold/load/shift/rotate/ASR/preset modes
// plus a burst controller running N shift steps with busy/done status.
module universal_shift_register #(
    parameter int DW    = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk_50MHz_i,
    input  logic             rst_async_la_i,
    input  logic             Enable_i,
    input  logic [2:0]       Mode_i,
    input  logic [DW-1:0]    D_i,
    input  logic             Serial_L_i,
    input  logic             Serial_R_i,
    input  logic             Start_i,
    input  logic [CNT_W-1:0] Count_i,
    output logic [DW-1:0]    Q_o,
    output logic             Serial_L_o,
    output logic             Serial_R_o,
    output logic             Busy_o,
    output logic             Done_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;
    localparam logic [2:0] M_SET  = 3'b111;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q;
    logic [2:0]       mode_q;
    logic [CNT_W-1:0] cnt_q;
    logic [DW-1:0]    q_q;
    logic             busy_q;
    logic             done_q;
    logic             start_shift;

    // Next register value for one application of an operation
    function automatic logic [DW-1:0] apply_op(
        input logic [2:0]    op,
        input logic [DW-1:0] q,
        input logic [DW-1:0] d,
        input logic          sl,
        input logic          sr
    );
        logic [DW-1:0] r;
        r = q;
        case (op)
            M_HOLD: r = q;
            M_LOAD: r = d;
            M_SHL:  r = {q[DW-2:0], sr};
            M_SHR:  r = {sl, q[DW-1:1]};
            M_ROL:  r = {q[DW-2:0], q[DW-1]};
            M_ROR:  r = {q[0], q[DW-1:1]};
            M_ASR:  r = {q[DW-1], q[DW-1:1]};
            M_SET:  r = '1;
            default: r = q;
        endcase
        return r;
    endfunction

    // Only shift-type modes can launch a burst
    assign start_shift = Start_i
                       && (Mode_i >= M_SHL)
                       && (Mode_i <= M_ASR);

    // Burst FSM, datapath register and registered status flags
    always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
        if (!rst_async_la_i) begin
            state_q <= IDLE;
            mode_q  <= M_HOLD;
            cnt_q   <= CNT_ZERO;
            q_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_shift) begin
                        mode_q <= Mode_i;
                        cnt_q  <= Count_i;
                        if (Count_i != CNT_ZERO) begin
                            state_q <= SHIFT;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end else if (Enable_i) begin
                        q_q <= apply_op(Mode_i, q_q, D_i,
                                        Serial_L_i, Serial_R_i);
                    end
                end
                SHIFT: begin
                    if (Enable_i) begin
                        q_q   <= apply_op(mode_q, q_q, D_i,
                                          Serial_L_i, Serial_R_i);
                        cnt_q <= cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Q_o        = q_q;
    assign Serial_L_o = q_q[DW-1];
    assign Serial_R_o = q_q[0];
    assign Busy_o     = busy_q;
    assign Done_o     = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Bench for universal_shift_register: directed scenarios plus random
// stimulus scored against a behavioural model via an expectation queue.
module tb_universal_shift_register;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [2:0]    mode;
    logic [DW-1:0] d;
    logic          sl;
    logic          sr;
    logic          start;
    logic [3:0]    cnt;
    logic [DW-1:0] q;
    logic          sl_o;
    logic          sr_o;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [DW-1:0] q;
        logic          busy;
        logic          done;
    } exp_t;

    exp_t sb[$];

    int            m_q;
    int            m_rem;
    int            m_mode;
    bit            m_done;

    universal_shift_register #(.DW(DW), .CNT_W(4)) dut (
        .clk_50MHz_i    (clk),
        .rst_async_la_i (rst_n),
        .Enable_i       (en),
        .Mode_i         (mode),
        .D_i            (d),
        .Serial_L_i     (sl),
        .Serial_R_i     (sr),
        .Start_i        (start),
        .Count_i        (cnt),
        .Q_o            (q),
        .Serial_L_o     (sl_o),
        .Serial_R_o     (sr_o),
        .Busy_o         (busy),
        .Done_o         (done)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference operation written as plain integer arithmetic on 0..255
    function automatic int ref_op(input int op, input int v,
                                  input int dv, input int l, input int r);
        case (op)
            0: return v;
            1: return dv;
            2: return (v * 2 + r) % 256;
            3: return v / 2 + l * 128;
            4: return (v * 2) % 256 + v / 128;
            5: return v / 2 + (v % 2) * 128;
            6: return v / 2 + (v / 128) * 128;
            default: return 255;
        endcase
    endfunction

    function automatic void model_edge();
        exp_t e;
        if (!rst_n) begin
            m_q = 0; m_rem = 0; m_done = 0;
        end else if (m_rem > 0) begin
            if (en) begin
                m_q = ref_op(m_mode, m_q, int'(d), int'(sl), int'(sr));
                m_rem--;
                if (m_rem == 0) m_done = 1;
            end
        end else if (m_done) begin
            m_done = 0;
        end else if (start && mode >= 2 && mode <= 6) begin
            m_mode = int'(mode);
            if (cnt == 0) m_done = 1;
            else m_rem = int'(cnt);
        end else if (en) begin
            m_q = ref_op(int'(mode), m_q, int'(d), int'(sl), int'(sr));
        end
        e.q    = DW'(m_q);
        e.busy = (m_rem > 0);
        e.done = m_done;
        sb.push_back(e);
    endfunction

    task automatic step(input bit e, input logic [2:0] md,
                        input logic [DW-1:0] dv, input bit l,
                        input bit r, input bit st,
                        input logic [3:0] c, input bit rs = 1'b1);
        @(negedge clk);
        en = e; mode = md; d = dv; sl = l; sr = r;
        start = st; cnt = c; rst_n = rs;
        model_edge();
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every cycle the DUT presents a new state, score it
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("mon_q",    int'(q),    int'(e.q));
            chk("mon_busy", int'(busy), int'(e.busy));
            chk("mon_done", int'(done), int'(e.done));
            chk("mon_sl_o", int'(sl_o), int'(e.q[DW-1]));
            chk("mon_sr_o", int'(sr_o), int'(e.q[0]));
        end
    end

    initial begin
        int saved;
        rst_n = 1'b0; en = 0; mode = 0; d = 0; sl = 0; sr = 0;
        start = 0; cnt = 0;
        m_q = 0; m_rem = 0; m_mode = 0; m_done = 0;
        #25;
        chk("reset_q", int'(q), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);

        // 2: load then disabled shift holds
        step(1, 3'b001, 8'hA5, 0, 0, 0, 0);
        settle();
        chk("load_a5", int'(q), 'hA5);
        step(0, 3'b010, 8'h00, 0, 1, 0, 0);
        settle();
        chk("en0_hold", int'(q), 'hA5);

        // 1: burst SHL 5, async reset after third shift
        step(1, 3'b010, 8'h00, 0, 1, 1, 4'd5);
        step(1, 3'b000, 8'h00, 0, 1, 0, 0);
        step(1, 3'b000, 8'h00, 0, 1, 0, 0);
        step(1, 3'b000, 8'h00, 0, 1, 0, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_q", int'(q), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        m_q = 0; m_rem = 0; m_done = 0;
        step(1, 3'b010, 8'h00, 0, 1, 0, 0, 1'b0);
        step(0, 3'b000, 8'h00, 0, 0, 0, 0, 1'b1);
        settle();
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_q", int'(q), 0);

        // 3: ROL burst of 3 from 0x81
        step(1, 3'b001, 8'h81, 0, 0, 0, 0);
        step(1, 3'b100, 8'h00, 0, 0, 1, 4'd3);
        settle();
        chk("rol_start_q", int'(q), 'h81);
        chk("rol_busy0", int'(busy), 1);
        step(1, 3'b000, 8'h00, 0, 0, 0, 0);
        settle();
        chk("rol_s1", int'(q), 'h03);
        step(1, 3'b000, 8'h00, 0, 0, 0, 0);
        settle();
        chk("rol_s2", int'(q), 'h06);
        chk("rol_busy2", int'(busy), 1);
        step(1, 3'b000, 8'h00, 0, 0, 0, 0);
        settle();
        chk("rol_s3", int'(q), 'h0C);
        chk("rol_done", int'(done), 1);
        chk("rol_busy3", int'(busy), 0);
        step(0, 3'b000, 8'h00, 0, 0, 0, 0);
        settle();
        chk("rol_done_off", int'(done), 0);

        // 4: ASR 2 steps with a stall
        step(1, 3'b001, 8'h80, 0, 0, 0, 0);
        step(1, 3'b110, 8'h00, 0, 0, 1, 4'd2);
        step(1, 3'b000, 8'h00, 0, 0, 0, 0);
        step(0, 3'b000, 8'h00, 0, 0, 0, 0);
        settle();
        chk("asr_stall_q", int'(q), 'hC0);
        chk("asr_stall_busy", int'(busy), 1);
        step(1, 3'b000, 8'h00, 0, 0, 0, 0);
        settle();
        chk("asr_final", int'(q), 'hE0);
        chk("asr_done", int'(done), 1);
        step(0, 3'b000, 8'h00, 0, 0, 0, 0);

        // 5: SHL 8 streaming ones, control toggles ignored
        step(1, 3'b001, 8'h00, 0, 0, 0, 0);
        step(1, 3'b010, 8'h00, 0, 1, 1, 4'd8);
        for (int i = 0; i < 7; i++)
            step(1, 3'(i), 8'h00, 0, 1, i[0], 4'd1);
        settle();
        chk("shl7_q", int'(q), 'h7F);
        chk("shl7_msb", int'(sl_o), 0);
        step(1, 3'b111, 8'h00, 0, 1, 1, 4'd3);
        settle();
        chk("shl8_q", int'(q), 'hFF);
        chk("shl8_msb", int'(sl_o), 1);
        chk("shl8_done", int'(done), 1);
        step(0, 3'b000, 8'h00, 0, 0, 0, 0);

        // 6: zero-length burst and preset with Start
        step(1, 3'b001, 8'h3C, 0, 0, 0, 0);
        settle();
        saved = int'(q);
        step(1, 3'b011, 8'h00, 1, 0, 1, 4'd0);
        settle();
        chk("cnt0_q", int'(q), saved);
        chk("cnt0_busy", int'(busy), 0);
        chk("cnt0_done", int'(done), 1);
        step(0, 3'b000, 8'h00, 0, 0, 0, 0);
        step(1, 3'b111, 8'h00, 0, 0, 1, 4'd5);
        settle();
        chk("preset_q", int'(q), 'hFF);
        chk("preset_done", int'(done), 0);
        chk("preset_busy", int'(busy), 0);

        // Random phase
        for (int i = 0; i < 500; i++) begin
            step(($urandom % 4) != 0,
                 3'($urandom % 8),
                 8'($urandom),
                 1'($urandom), 1'($urandom),
                 ($urandom % 6) == 0,
                 4'($urandom % 16));
        end
        for (int i = 0; i < 20; i++)
            step(1, 3'b000, 8'h00, 0, 0, 0, 0);
        settle();
        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
